// File: rtl/fp_round_arbiter.sv
// Round-robin arbiter feeding a shared 2-stage single-precision rounding pipeline.
// Stage 1 captures the granted operand and its round-up decision; stage 2 applies carry/overflow.
module fp_round_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_sign,
    input  logic [8*NUM_REQ-1:0]   req_exp,
    input  logic [23*NUM_REQ-1:0]  req_mant,
    input  logic [3*NUM_REQ-1:0]   req_grs,
    input  logic [3*NUM_REQ-1:0]   req_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_sign,
    output logic [7:0]             out_exp,
    output logic [22:0]            out_mant,
    output logic                   out_inexact,
    output logic                   out_overflow
);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [ID_W-1:0] r_s1_id;
    logic            r_s1_sign;
    logic [7:0]      r_s1_exp;
    logic [22:0]     r_s1_mant;
    logic            r_s1_rup;
    logic            r_s1_inexact;

    logic            w_adv1;
    logic            w_adv2;
    logic            w_gnt_any;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W-1:0] w_ptr_next;
    logic            w_sel_sign;
    logic [7:0]      w_sel_exp;
    logic [22:0]     w_sel_mant;
    logic [2:0]      w_sel_grs;
    logic [2:0]      w_sel_rm;
    logic            w_rup;
    logic            w_inexact;
    logic [23:0]     w_sum;
    logic [7:0]      w_exp_inc;

    assign w_adv2 = ~out_valid | out_ready;
    assign w_adv1 = ~r_s1_valid | w_adv2;

    // Rotating priority scan starting at the pointer; also muxes the winner's operand.
    always_comb begin
        int idx;
        idx        = 0;
        w_gnt_any  = 1'b0;
        w_gnt_id   = '0;
        w_sel_sign = 1'b0;
        w_sel_exp  = '0;
        w_sel_mant = '0;
        w_sel_grs  = '0;
        w_sel_rm   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_gnt_any && req_valid[idx]) begin
                w_gnt_any  = 1'b1;
                w_gnt_id   = ID_W'(idx);
                w_sel_sign = req_sign[idx];
                w_sel_exp  = req_exp[8*idx +: 8];
                w_sel_mant = req_mant[23*idx +: 23];
                w_sel_grs  = req_grs[3*idx +: 3];
                w_sel_rm   = req_rm[3*idx +: 3];
            end
        end
    end

    assign req_ready  = (w_gnt_any && w_adv1) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin
        case (w_sel_rm)
            3'd0:    w_rup = w_sel_grs[2] & (w_sel_grs[1] | w_sel_grs[0] | w_sel_mant[0]);
            3'd1:    w_rup = 1'b0;
            3'd2:    w_rup = w_sel_sign & (|w_sel_grs);
            3'd3:    w_rup = ~w_sel_sign & (|w_sel_grs);
            3'd4:    w_rup = w_sel_grs[2];
            default: w_rup = 1'b0;
        endcase
        // Inf/NaN inputs pass through untouched and never flag inexact.
        if (w_sel_exp == 8'hFF) w_rup = 1'b0;
        w_inexact = (|w_sel_grs) & (w_sel_exp != 8'hFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_id      <= '0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_mant    <= '0;
            r_s1_rup     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_ptr        <= w_ptr_next;
                r_s1_id      <= w_gnt_id;
                r_s1_sign    <= w_sel_sign;
                r_s1_exp     <= w_sel_exp;
                r_s1_mant    <= w_sel_mant;
                r_s1_rup     <= w_rup;
                r_s1_inexact <= w_inexact;
            end
        end
    end

    assign w_sum     = {1'b0, r_s1_mant} + {23'd0, r_s1_rup};
    assign w_exp_inc = r_s1_exp + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_sign     <= 1'b0;
            out_exp      <= '0;
            out_mant     <= '0;
            out_inexact  <= 1'b0;
            out_overflow <= 1'b0;
        end else if (w_adv2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_id      <= r_s1_id;
                out_sign    <= r_s1_sign;
                out_inexact <= r_s1_inexact;
                if (w_sum[23]) begin
                    out_mant <= '0;
                    if (r_s1_exp == 8'hFE) begin
                        out_exp      <= 8'hFF;
                        out_overflow <= 1'b1;
                    end else begin
                        out_exp      <= w_exp_inc;
                        out_overflow <= 1'b0;
                    end
                end else begin
                    out_mant     <= w_sum[22:0];
                    out_exp      <= r_s1_exp;
                    out_overflow <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fp_round_arbiter.md
Name: fp_round_arbiter

Overview:
- Shares one pipelined rounding stage among NUM_REQ upstream producers, such as the adder, multiplier and divider normalisers.
- Each producer presents an unrounded single-precision result: sign, biased exponent, 23-bit mantissa, guard/round/sticky bits and a rounding mode.
- A round-robin arbiter admits one operation per cycle into a 2-stage pipeline. The pipeline applies the rounding decision, mantissa-carry overflow and exponent overflow, then returns a tagged result through a valid/ready output.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high.
- req_sign  in  NUM_REQ  sign bit, one per requester.
- req_exp  in  8*NUM_REQ  biased exponents, requester i at [8i+7:8i].
- req_mant  in  23*NUM_REQ  unrounded mantissas, requester i at [23i+22:23i].
- req_grs  in  3*NUM_REQ  {guard, round, sticky}, requester i at [3i+2:3i].
- req_rm  in  3*NUM_REQ  rounding mode per fp_pkg: RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_id  out  ID_W  index of the originating requester.
- out_sign  out  1  result sign.
- out_exp  out  8  rounded exponent.
- out_mant  out  23  rounded mantissa.
- out_inexact  out  1  guard|round|sticky was nonzero.
- out_overflow  out  1  rounding pushed the exponent to 255.

Behaviour:
- Reset: asynchronous.
  - All pipeline valids go to 0 and the round-robin pointer goes to 0.
  - out_valid, out_id, out_sign, out_exp, out_mant, out_inexact and out_overflow all reset to 0.
  - Reset asserted mid-operation discards all in-flight operations; nothing is emitted.
- Pipeline control:
  - adv2 = ~out_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - The output register loads from stage 1 when adv2 is high. out_valid becomes s1_valid on that load.
  - While out_valid=1 and out_ready=0, all output fields hold stable.
- Arbitration (combinational, same cycle):
  - When adv1=1, grant the first requester with req_valid=1, scanning from the pointer upward and wrapping mod NUM_REQ.
  - req_ready is one-hot or zero. It is zero whenever adv1=0.
  - req_ready never depends on the requester's own data.
  - After a grant to index i, pointer <= (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Stage 1 (registered on grant):
  - Captures id, sign, exp, mant and grs from the granted requester.
  - Computes round_up from the captured mode:
    - RNE: g&(r|s|mant[0]).
    - RTZ: 0.
    - RDN: sign&(g|r|s).
    - RUP: ~sign&(g|r|s).
    - RMM: g.
    - Modes 5..7: 0.
  - If exp==255 (Inf/NaN input): round_up forced to 0, inexact forced to 0, and the value passes through unchanged.
  - s1_valid <= grant_any when adv1=1.
- Stage 2 (output register):
  - sum = {1'b0,mant} + round_up, 24 bits.
  - If sum[23]=1 (mantissa carry): out_mant = 0 and out_exp = exp + 1.
  - If that exp + 1 equals 255: out_overflow = 1, out_exp = 255, out_mant = 0. The result is infinity with the preserved sign.
  - Otherwise: out_mant = sum[22:0], out_exp = exp, out_overflow = 0.
  - out_inexact = |grs, except on the Inf/NaN pass-through where it is 0.
- Latency and throughput:
  - A request accepted in cycle T appears on out_valid in T+2 when no stall occurs.
  - Throughput is 1 operation per cycle under continuous out_ready.
- Ordering: results emerge in grant order. Each result carries out_id of the requester it came from.
- Full pipeline: with both stages valid and out_ready=0, req_ready=0 for all requesters. No operation is lost or duplicated.
- Simultaneous events: in one cycle, out_ready=1 with both stages full drains the output, shifts stage 1 forward and grants a new request.

Test Plan:
- Single request, requester 1, RNE: exp=0x80, mant=0x000001, grs=100 -> out at T+2, id=1, mant=0x000002, exp=0x80, inexact=1.
- Mantissa carry, RUP, sign=0: mant=0x7FFFFF, exp=0x7E, grs=001 -> mant=0, exp=0x7F, overflow=0, inexact=1.
- Exponent overflow, RMM: exp=0xFE, mant=0x7FFFFF, grs=100 -> exp=0xFF, mant=0, overflow=1.
- All 3 requesters valid continuously, out_ready=1 -> grants in order 0,1,2,0,1,2, one per cycle. out_id sequence matches.
- out_ready held low 5 cycles with 3 pending requests -> exactly 2 accepted, outputs stable throughout. On release, results are in order with no loss or duplication.
- rst pulsed while 2 ops are in flight -> out_valid=0 immediately, pointer=0. The next accepted request is the first result emitted.
